// File: rtl/store_gen_pkg.sv
// Purpose: shared encodings, row geometry and helpers for the store data generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package store_gen_pkg;

    // Store size encodings carried in typ[1:0]
    localparam logic [1:0] MT_B = 2'b00;
    localparam logic [1:0] MT_H = 2'b01;
    localparam logic [1:0] MT_W = 2'b10;
    localparam logic [1:0] MT_D = 2'b11;

    localparam int ROW_BYTES = 16;
    localparam int ROW_OFF_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Widen a per-byte enable into a per-bit enable across one row
    function automatic logic [ROW_BYTES*8-1:0] expand_mask(input logic [ROW_BYTES-1:0] m);
        logic [ROW_BYTES*8-1:0] e;
        for (int i = 0; i < ROW_BYTES; i++) begin
            e[8*i +: 8] = {8{m[i]}};
        end
        return e;
    endfunction

endpackage

// File: rtl/store_data_fmt.sv
// Purpose: place a right-justified store into its 128-bit row slot and build the byte mask.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: i_size (typ[1:0]), i_off (addr[3:0]), i_data (64b store data)
//        -> o_new_data (128b row image), o_new_mask (16b byte enables), o_misaligned.
module store_data_fmt
    import store_gen_pkg::*;
(
    input  logic [1:0]           i_size,
    input  logic [ROW_OFF_W-1:0] i_off,
    input  logic [63:0]          i_data,
    output logic [127:0]         o_new_data,
    output logic [15:0]          o_new_mask,
    output logic                 o_misaligned
);

    logic [7:0]  w_size_bytes;
    logic [63:0] w_data_sz;

    always_comb begin
        w_size_bytes = 8'h01;
        o_misaligned = 1'b0;
        case (i_size)
            MT_B: begin
                w_size_bytes = 8'h01;
                o_misaligned = 1'b0;
            end
            MT_H: begin
                w_size_bytes = 8'h03;
                o_misaligned = i_off[0];
            end
            MT_W: begin
                w_size_bytes = 8'h0F;
                o_misaligned = |i_off[1:0];
            end
            MT_D: begin
                w_size_bytes = 8'hFF;
                o_misaligned = |i_off[2:0];
            end
        endcase

        // Zero the bytes above the store size before shifting into the row
        w_data_sz = '0;
        for (int i = 0; i < 8; i++) begin
            w_data_sz[8*i +: 8] = i_data[8*i +: 8] & {8{w_size_bytes[i]}};
        end

        o_new_mask = {8'h00, w_size_bytes} << i_off;
        o_new_data = {64'h0, w_data_sz} << {i_off, 3'b000};
    end

endmodule

// File: rtl/store_data_gen.sv
// Purpose: format stores and combine same-row stores in a one-entry buffer before one masked row write.
// Latency: an isolated store reaches o_wr_valid HOLD_CYCLES+1 cycles after acceptance.
// Backpressure: o_req_ready drops while draining or when a different-row store must wait; o_wr_valid holds until i_wr_ready.
// Ports: i_req_* store request (valid/ready), i_flush forces a drain, o_wr_* masked row write (valid/ready),
//        o_xcpt_ma/o_xcpt_addr one-cycle misaligned-store report, o_idle buffer empty.
module store_data_gen
    import store_gen_pkg::*;
#(
    parameter int ADDR_W      = 40,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_req_typ,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [63:0]       i_req_data,
    input  logic              i_flush,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-5:0] o_wr_addr,
    output logic [127:0]      o_wr_data,
    output logic [15:0]       o_wr_mask,
    output logic              o_xcpt_ma,
    output logic [ADDR_W-1:0] o_xcpt_addr,
    output logic              o_idle
);

    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);

    state_e              r_state;
    logic [ADDR_W-5:0]   r_row;
    logic [127:0]        r_data;
    logic [15:0]         r_mask;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_xcpt_ma;
    logic [ADDR_W-1:0]   r_xcpt_addr;

    state_e              w_next_state;
    logic [127:0]        w_new_data;
    logic [15:0]         w_new_mask;
    logic                w_misaligned;
    logic                w_same_row;
    logic                w_req_ready;
    logic                w_load;
    logic                w_merge;
    logic                w_tick;
    logic                w_accept;
    logic                w_unused;

    // The unsigned flag only matters for loads
    assign w_unused = i_req_typ[2];

    store_data_fmt u_fmt (
        .i_size       (i_req_typ[1:0]),
        .i_off        (i_req_addr[ROW_OFF_W-1:0]),
        .i_data       (i_req_data),
        .o_new_data   (w_new_data),
        .o_new_mask   (w_new_mask),
        .o_misaligned (w_misaligned)
    );

    assign w_same_row = (i_req_addr[ADDR_W-1:ROW_OFF_W] == r_row);
    assign w_accept   = i_req_valid && w_req_ready;

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_load       = 1'b0;
        w_merge      = 1'b0;
        w_tick       = 1'b0;
        case (r_state)
            EMPTY: begin
                w_req_ready = 1'b1;
                if (i_req_valid && !w_misaligned) begin
                    w_load       = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (i_flush) begin
                    w_next_state = DRAIN;
                end else if (i_req_valid && !w_misaligned && w_same_row) begin
                    // A merge restarts the hold window even if it was about to expire
                    w_req_ready = 1'b1;
                    w_merge     = 1'b1;
                end else if (i_req_valid && !w_misaligned) begin
                    // Different row: stall it, drain, then take it from EMPTY
                    w_next_state = DRAIN;
                end else begin
                    // Idle or misaligned (consumed without touching the entry)
                    w_req_ready = 1'b1;
                    if (r_timer == TIMER_LAST) begin
                        w_next_state = DRAIN;
                    end else begin
                        w_tick = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (i_wr_ready) begin
                    w_next_state = EMPTY;
                end
            end
            default: begin
                w_next_state = EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= EMPTY;
            r_row       <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_timer     <= '0;
            r_xcpt_ma   <= 1'b0;
            r_xcpt_addr <= '0;
        end else begin
            r_state   <= w_next_state;
            r_xcpt_ma <= w_accept && w_misaligned;
            if (w_accept && w_misaligned) begin
                r_xcpt_addr <= i_req_addr;
            end
            if (w_load) begin
                r_row   <= i_req_addr[ADDR_W-1:ROW_OFF_W];
                r_data  <= w_new_data;
                r_mask  <= w_new_mask;
                r_timer <= '0;
            end else if (w_merge) begin
                r_data  <= (r_data & ~expand_mask(w_new_mask)) | w_new_data;
                r_mask  <= r_mask | w_new_mask;
                r_timer <= '0;
            end else if (w_tick) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == DRAIN && i_wr_ready) begin
                r_mask <= '0;
            end
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_wr_valid  = (r_state == DRAIN);
    assign o_wr_addr   = r_row;
    assign o_wr_data   = r_data;
    assign o_wr_mask   = r_mask;
    assign o_xcpt_ma   = r_xcpt_ma;
    assign o_xcpt_addr = r_xcpt_addr;
    assign o_idle      = (r_state == EMPTY);

endmodule

// File: tb/tb_store_data_gen.sv
// Purpose: randomized scoreboard bench for store_data_gen with a byte-array reference model.
// Latency: n/a.
// Backpressure: bench drives i_wr_ready fixed or random.
module tb_store_data_gen;

    localparam int AW = 40;
    localparam int HC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_typ;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_data;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-5:0] wr_addr;
    logic [127:0]  wr_data;
    logic [15:0]   wr_mask;
    logic          xcpt_ma;
    logic [AW-1:0] xcpt_addr;
    logic          idle;

    store_data_gen #(.ADDR_W(AW), .HOLD_CYCLES(HC)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_typ   (req_typ),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .i_flush     (flush),
        .o_wr_valid  (wr_valid),
        .i_wr_ready  (wr_ready),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_wr_mask   (wr_mask),
        .o_xcpt_ma   (xcpt_ma),
        .o_xcpt_addr (xcpt_addr),
        .o_idle      (idle)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-5:0] row;
        logic [127:0]  data;
        logic [15:0]   mask;
    } wr_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_x[$];

    // Reference model: the pending row as an array of bytes plus written flags
    logic [7:0]    m_bytes[16];
    logic [15:0]   m_mask;
    logic [AW-5:0] m_row;
    bit            m_valid = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic model_store(input logic [2:0] typ, input logic [AW-1:0] addr, input logic [63:0] data);
        int sz;
        int off;
        sz  = 1 << typ[1:0];
        off = int'(addr[3:0]);
        if ((off % sz) != 0) begin
            exp_x.push_back(addr);
        end else begin
            if (!m_valid || m_row != addr[AW-1:4]) begin
                model_close();
                m_valid = 1;
                m_row   = addr[AW-1:4];
                m_mask  = '0;
                for (int i = 0; i < 16; i++) m_bytes[i] = 8'h00;
            end
            for (int k = 0; k < sz; k++) begin
                m_bytes[off + k] = data[8*k +: 8];
                m_mask[off + k]  = 1'b1;
            end
        end
    endtask

    task automatic model_close();
        wr_t w;
        if (m_valid) begin
            w.row  = m_row;
            w.mask = m_mask;
            for (int i = 0; i < 16; i++) w.data[8*i +: 8] = m_bytes[i];
            exp_wr.push_back(w);
            m_valid = 0;
        end
    endtask

    task automatic send(input logic [2:0] typ, input logic [AW-1:0] addr, input logic [63:0] data,
                        output int waits);
        bit done;
        req_valid = 1'b1;
        req_typ   = typ;
        req_addr  = addr;
        req_data  = data;
        waits     = 0;
        done      = 0;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
                model_store(typ, addr, data);
            end else begin
                waits++;
                if (waits > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL req_accept_timeout addr=%0h", addr);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Random write backpressure when enabled
    bit rand_rdy = 0;
    always @(posedge clk) begin
        #1;
        if (rand_rdy) wr_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops expectations whenever the DUT presents a write or exception
    bit            prev_stall = 0;
    logic [AW-5:0] prev_addr;
    logic [127:0]  prev_data;
    logic [15:0]   prev_mask;
    wr_t           mon_w;
    logic [AW-1:0] mon_x;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 128'(wr_valid), 128'(1));
                chk("stall_addr", 128'(wr_addr), 128'(prev_addr));
                chk("stall_data", wr_data, prev_data);
                chk("stall_mask", 128'(wr_mask), 128'(prev_mask));
            end
            if (wr_valid && wr_ready) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0h mask=%0h", wr_addr, wr_mask);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_addr", 128'(wr_addr), 128'(mon_w.row));
                    chk("wr_data", wr_data, mon_w.data);
                    chk("wr_mask", 128'(wr_mask), 128'(mon_w.mask));
                end
            end
            if (xcpt_ma) begin
                if (exp_x.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xcpt addr=%0h", xcpt_addr);
                end else begin
                    mon_x = exp_x.pop_front();
                    chk("xcpt_addr", 128'(xcpt_addr), 128'(mon_x));
                end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
            prev_mask  = wr_mask;
        end
    end

    function automatic logic [AW-1:0] mk_addr(input logic [AW-5:0] row, input int off);
        return {row, 4'(off)};
    endfunction

    initial begin
        int            w;
        int            n;
        int            nslots;
        int            endk;
        int            sz;
        int            off;
        int            gap;
        bit            force_new;
        bit            prev_mis;
        logic [2:0]    typ;
        logic [AW-5:0] cur_row;
        logic [AW-5:0] last_row;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_typ   = '0;
        req_addr  = '0;
        req_data  = '0;
        flush     = 1'b0;
        wr_ready  = 1'b1;
        idle_cycles(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_idle", 128'(idle), 128'(1));
        chk("rst_wr_valid", 128'(wr_valid), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(1));
        chk("rst_xcpt", 128'(xcpt_ma), 128'(0));
        chk("rst_mask", 128'(wr_mask), 128'(0));
        @(posedge clk);
        #1;

        // Isolated byte store: latency and placement
        send(3'b000, 40'h1003, 64'hAB, w);
        model_close();
        n = 0;
        while (!wr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sb_latency", 128'(n), 128'(HC + 1));
        idle_cycles(3);
        @(negedge clk);
        chk("sb_idle_after", 128'(idle), 128'(1));
        @(posedge clk);
        #1;

        // Doubleword then word into the same row, back to back
        send(3'b011, 40'h2008, 64'h1122334455667788, w);
        send(3'b010, 40'h200C, 64'hDEADBEEF, w);
        chk("merge_no_stall", 128'(w), 128'(0));
        model_close();
        idle_cycles(HC + 3);

        // Misaligned halfword in EMPTY
        send(3'b001, 40'h3001, 64'h5555, w);
        chk("mis_ready", 128'(w), 128'(0));
        @(negedge clk);
        chk("mis_idle", 128'(idle), 128'(1));
        idle_cycles(2);

        // Different-row store stalls behind the drain
        send(3'b010, 40'h4000, 64'h0A0B0C0D, w);
        model_close();
        send(3'b010, 40'h4010, 64'h01020304, w);
        chk("diff_row_waits", 128'(w), 128'(2));
        model_close();
        idle_cycles(HC + 3);

        // Flush in HOLD, then stall the write for three cycles
        wr_ready = 1'b0;
        send(3'b001, 40'h5006, 64'hBEEF, w);
        model_close();
        flush_pulse();
        @(negedge clk);
        chk("flush_drain", 128'(wr_valid), 128'(1));
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", 128'(wr_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        idle_cycles(2);

        // Reset while draining discards the entry
        wr_ready = 1'b0;
        send(3'b011, 40'h6000, 64'hFEEDFACECAFEF00D, w);
        flush_pulse();
        @(negedge clk);
        chk("pre_rst_drain", 128'(wr_valid), 128'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_valid = 0;
        @(negedge clk);
        chk("rst_drain_valid", 128'(wr_valid), 128'(0));
        chk("rst_drain_idle", 128'(idle), 128'(1));
        chk("rst_drain_mask", 128'(wr_mask), 128'(0));
        chk("rst_drain_data", wr_data, 128'(0));
        @(posedge clk);
        #1;
        wr_ready = 1'b1;

        // Randomized groups of same-row stores with assorted closing events
        rand_rdy  = 1;
        force_new = 0;
        last_row  = '0;
        for (int g = 0; g < 120; g++) begin
            do begin
                cur_row = 36'h00ABC0 + 36'($urandom_range(0, 3));
            end while (force_new && cur_row == last_row);
            nslots   = $urandom_range(1, 4);
            prev_mis = 0;
            for (int s = 0; s < nslots; s++) begin
                if (s > 0 && !prev_mis && $urandom_range(0, 3) == 0) begin
                    typ = 3'($urandom_range(1, 3));
                    sz  = 1 << typ[1:0];
                    off = $urandom_range(0, 15);
                    if ((off % sz) == 0) off = off | 1;
                    typ[2] = 1'($urandom_range(0, 1));
                    send(typ, mk_addr(cur_row, off), {$urandom, $urandom}, w);
                    prev_mis = 1;
                end else begin
                    gap = (s == 0) ? 0 : $urandom_range(0, 1);
                    idle_cycles(gap);
                    typ = 3'($urandom_range(0, 7));
                    sz  = 1 << typ[1:0];
                    off = $urandom_range(0, 15) & ~(sz - 1);
                    send(typ, mk_addr(cur_row, off), {$urandom, $urandom}, w);
                    prev_mis = 0;
                end
            end
            model_close();
            last_row  = cur_row;
            force_new = 0;
            endk = $urandom_range(0, 2);
            if (endk == 0) begin
                idle_cycles(HC + 3);
            end else if (endk == 1) begin
                flush_pulse();
            end else begin
                force_new = 1;
            end
        end

        // Let everything drain
        idle_cycles(HC + 2);
        rand_rdy = 0;
        wr_ready = 1'b1;
        n = 0;
        while ((exp_wr.size() != 0 || exp_x.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        chk("end_wr_queue", 128'(exp_wr.size()), 128'(0));
        chk("end_x_queue", 128'(exp_x.size()), 128'(0));
        chk("end_idle", 128'(idle), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
